// File: rtl/sample_tdm_scheduler_if.sv
// Sample path bundle between the channel sources, the TDM scheduler and the
// downstream stage.
//   req/data_in : per-channel request level and packed samples (ch i at [i*WIDTH +: WIDTH])
//   ack         : one-cycle consume pulse back to the granted channel
//   out_*       : valid/ready output carrying the granted sample and channel index
// master = scheduler side, slave = sources/downstream side.
interface sample_tdm_scheduler_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 5
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH-1:0]       ack;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_ch;

  modport master (
    input  req, data_in, out_ready,
    output ack, out_valid, out_data, out_ch
  );

  modport slave (
    output req, data_in, out_ready,
    input  ack, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/sample_tdm_scheduler.sv
// Round-robin TDM scheduler sharing one sample path between NCH channels.
// A slot divider produces a tick every DIV enabled cycles; on a tick one
// requesting channel is granted, its sample captured and offered downstream.
//   clk, rst_n  : clock, async active-low reset
//   enable      : run the slot divider (low holds it at 0)
//   clr_overrun : clears the sticky overrun flag
//   tick        : one-cycle slot strobe (combinational from the divider)
//   overrun     : sticky, a slot was dropped while the output was stalled
//   bus         : request/sample/ack and valid/ready output bundle
module sample_tdm_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DIV   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clr_overrun,
  output logic tick,
  output logic overrun,
  sample_tdm_scheduler_if.master bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DW  = $clog2(DIV);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt;
  logic [CHW-1:0]   last, last_n;
  logic [CHW-1:0]   gnt;
  logic             gnt_vld;
  logic             hs, load;
  logic             valid_n, ovr_n;
  logic [WIDTH-1:0] data_n;
  logic [CHW-1:0]   ch_n;
  logic [NCH-1:0]   ack_n;
  logic [WIDTH-1:0] chan_data [NCH];

  // Slot divider: counts 0..DIV-1 while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = enable && (div_cnt == DW'(DIV - 1));

  // Unpack channel samples
  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign chan_data[i] = bus.data_in[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!gnt_vld && bus.req[CHW'((32'(last) + k) % NCH)]) begin
        gnt     = CHW'((32'(last) + k) % NCH);
        gnt_vld = 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= CHW'(NCH - 1);
      overrun       <= 1'b0;
      bus.ack       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else begin
      state         <= state_n;
      last          <= last_n;
      overrun       <= ovr_n;
      bus.ack       <= ack_n;
      bus.out_valid <= valid_n;
      bus.out_data  <= data_n;
      bus.out_ch    <= ch_n;
    end
  end

  // Next-state: a tick is serviced when idle or when the held sample leaves
  // in the same cycle; otherwise a requested slot is dropped and flagged.
  always_comb begin
    state_n = state;
    last_n  = last;
    valid_n = bus.out_valid;
    data_n  = bus.out_data;
    ch_n    = bus.out_ch;
    ack_n   = '0;
    ovr_n   = overrun & ~clr_overrun;
    hs      = bus.out_valid & bus.out_ready;
    load    = 1'b0;

    case (state)
      IDLE: begin
        load = tick & gnt_vld;
      end
      SEND: begin
        if (hs) begin
          load = tick & gnt_vld;
          if (!load) begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else if (tick && gnt_vld) begin
          ovr_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      state_n    = SEND;
      valid_n    = 1'b1;
      data_n     = chan_data[gnt];
      ch_n       = gnt;
      last_n     = gnt;
      ack_n[gnt] = 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_tdm_scheduler.sv
// Bench for sample_tdm_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a slot-level reference model.
module tb_sample_tdm_scheduler;
  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned DIV   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic clr_overrun;
  logic tick;
  logic overrun;

  sample_tdm_scheduler_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  sample_tdm_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clr_overrun (clr_overrun),
    .tick        (tick),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (what the outputs should read after each edge)
  int m_cnt, m_last, m_data, m_ch, m_ack, m_ovr;
  bit m_valid;
  int n_vec = 0;
  int n_err = 0;
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = NCH - 1; m_data = 0; m_ch = 0;
    m_ack = 0; m_ovr = 0; m_valid = 0;
  endtask

  // One clock edge worth of scheduler behaviour, from the current inputs
  task automatic model_step();
    bit tk, hs;
    int g, c, nxt_ovr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = enable && (m_cnt == DIV - 1);
    hs = m_valid && bus.out_ready;
    g  = -1;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_last + k) % NCH;
      if (g < 0 && ((32'(bus.req) >> c) & 1) == 1) g = c;
    end
    nxt_ovr = clr_overrun ? 0 : m_ovr;
    m_ack = 0;
    if (tk && g >= 0 && (!m_valid || hs)) begin
      m_valid = 1;
      m_data  = (32'(bus.data_in) >> (g * WIDTH)) & ((1 << WIDTH) - 1);
      m_ch    = g;
      m_last  = g;
      m_ack   = 1 << g;
    end else if (hs) begin
      m_valid = 0;
    end else if (tk && g >= 0) begin
      nxt_ovr = 1;
    end
    m_ovr = nxt_ovr;
    m_cnt = !enable ? 0 : ((m_cnt == DIV - 1) ? 0 : m_cnt + 1);
  endtask

  task automatic check_all();
    chk("tick",      32'(tick),          32'(enable && (m_cnt == DIV - 1)));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  m_data);
    chk("out_ch",    32'(bus.out_ch),    m_ch);
    chk("ack",       32'(bus.ack),       m_ack);
    chk("overrun",   32'(overrun),       m_ovr);
  endtask

  // Advance one clock, then compare on the falling edge
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_all();
    if (m_ack != 0) grants.push_back(m_ch);
  endtask

  initial begin
    int exp_seq[5];
    int exp_alt[4];
    int ch_before;
    int nticks;
    bit found;

    rst_n = 1'b0; enable = 1'b0; clr_overrun = 1'b0;
    bus.req = '0; bus.out_ready = 1'b0; bus.data_in = '0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;

    // All channels requesting: strict rotation 0,1,2,3,0
    enable = 1'b1; bus.req = 4'b1111; bus.out_ready = 1'b1;
    bus.data_in = 20'($urandom);
    grants.delete();
    repeat (5 * DIV + 2) cycle();
    exp_seq = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(exp_seq[i]));

    // Sparse requests: 1,3 alternate
    bus.req = 4'b1010; bus.data_in = 20'($urandom);
    grants.delete();
    repeat (4 * DIV) cycle();
    exp_alt = '{1, 3, 1, 3};
    chk("alt_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("alt_order", 32'(grants[i]), 32'(exp_alt[i]));

    // Captured sample is held while downstream stalls
    bus.req = 4'b0100; bus.out_ready = 1'b0;
    bus.data_in[2*WIDTH +: WIDTH] = 5'h15;
    found = 0;
    for (int i = 0; i < 3 * DIV && !found; i++) begin
      cycle();
      if (m_ack != 0) found = 1;
    end
    chk("grant_seen", 32'(found), 32'd1);
    bus.data_in[2*WIDTH +: WIDTH] = 5'h0A;
    repeat (3) cycle();
    chk("hold_data", 32'(bus.out_data), 32'h15);
    chk("hold_ch",   32'(bus.out_ch),   32'd2);
    bus.out_ready = 1'b1;
    cycle();

    // Stall across two ticks sets overrun; clear afterwards
    bus.req = 4'b0011; bus.out_ready = 1'b0;
    repeat (2 * DIV + 2) cycle();
    chk("ovr_set", 32'(overrun), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    cycle();

    // Handshake lands exactly on a tick: back-to-back grant
    bus.out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 4 * DIV && !found; i++) begin
      cycle();
      if (m_valid && m_cnt == DIV - 1) found = 1;
    end
    chk("b2b_reach", 32'(found), 32'd1);
    ch_before = int'(bus.out_ch);
    bus.out_ready = 1'b1;
    cycle();
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_moved", 32'(int'(bus.out_ch) != ch_before), 32'd1);
    chk("b2b_ovr",   32'(overrun), 32'd0);

    // Async reset while a sample is pending
    bus.req = 4'b1111; bus.out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 3 * DIV && !found; i++) begin
      cycle();
      if (m_valid && m_ack == 0) found = 1;
    end
    chk("pend_reach", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ack",   32'(bus.ack),       32'd0);
    chk("rst_ch",    32'(bus.out_ch),    32'd0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    grants.delete();
    repeat (DIV + 2) cycle();
    chk("post_rst_cnt", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) chk("post_rst_ch0", 32'(grants[0]), 32'd0);

    // Divider held: no ticks at all
    enable = 1'b0;
    nticks = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      cycle();
      if (tick) nticks++;
    end
    chk("no_tick", 32'(nticks), 32'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.req       = 4'($urandom_range(0, 15));
      bus.data_in   = 20'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      clr_overrun   = ($urandom % 16) == 0;
      enable        = ($urandom % 64) != 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sample_tdm_scheduler.md
Name: sample_tdm_scheduler

Overview:
Round-robin time-division scheduler that shares one 5-bit sample path between NCH channel sources. A programmable divider generates the sample-slot tick. On each tick the scheduler grants one requesting channel, captures its sample, and presents it on a valid/ready output toward the downstream crossing/modulator stage. Single clock domain; it sits on the fast-clock side ahead of the shared datapath.

Parameters:
NCH, 4, number of requesting channels (2..16)
WIDTH, 5, sample width in bits
DIV, 16, clocks per sample slot (>=2)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run slot divider; low holds divider at 0
req  in  NCH  per-channel sample-available request, level
data_in  in  NCH*WIDTH  channel samples, channel i at bits [i*WIDTH +: WIDTH]
ack  out  NCH  one-cycle pulse: channel sample consumed
tick  out  1  one-cycle slot strobe
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts sample
out_data  out  WIDTH  granted sample
out_ch  out  max(1,$clog2(NCH))  granted channel index
overrun  out  1  sticky: a slot was dropped
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (async, rst_n=0): divider=0, tick=0, ack=0, out_valid=0, out_data=0, out_ch=0, overrun=0, FSM=IDLE, rr pointer last=NCH-1 (channel 0 wins first).
- Divider: when enable=1, counts 0..DIV-1 and wraps; tick=1 combinationally for exactly the cycle count==DIV-1. enable=0 -> count forced to 0, tick=0. First tick occurs DIV cycles after enable rises.
- Arbitration: on a serviced tick, grant g = first index with req[g]=1 searching last+1, last+2, ... wrapping modulo NCH. last<=g. No req at tick -> no grant, no overrun, pointer unchanged.
- FSM IDLE: tick with req!=0 -> next cycle out_valid=1, out_data=data_in[g] as sampled in the tick cycle, out_ch=g, ack[g]=1 for that one cycle; state SEND. Latency tick -> out_valid = 1 cycle.
- FSM SEND: out_valid, out_data, out_ch held stable until out_valid&out_ready. Handshake cycle without tick -> next cycle out_valid=0, IDLE.
- Tick in SEND with handshake same cycle: tick serviced; new grant loaded next cycle, out_valid stays 1 (back-to-back), ack pulses for new channel; no overrun. If req==0, go to IDLE.
- Tick in SEND without handshake: slot dropped, overrun<=1, pointer unchanged, output held.
- enable falling during SEND does not abort; the pending sample completes normally.
- overrun: sticky; clr_overrun=1 clears it next cycle; a set event in the same cycle as clr_overrun wins (overrun stays 1).
- ack is never asserted for more than one channel or more than one cycle per grant.
- Reset asserted mid-SEND: output drops immediately (async); sample lost, no ack replay.

Test Plan:
- Reset, enable=1, DIV=16, req=4'b1111, out_ready=1 -> ticks every 16 cycles; out_ch sequence 0,1,2,3,0; ack pulse 1 cycle after each tick; out_valid one cycle per slot.
- req=4'b1010 constant, out_ready=1 -> out_ch alternates 1,3,1,3; channels 0,2 never acked.
- data_in ch2=5'h15, req=4'b0100; change data to 5'h0A the cycle after tick -> out_data=5'h15 held until handshake.
- out_ready=0 across two ticks -> overrun=1 after second tick, out_data/out_ch unchanged; out_ready=1 -> handshake, IDLE; pulse clr_overrun -> overrun=0.
- out_ready asserted exactly on tick cycle with req=4'b0011 -> out_valid stays high, out_ch moves 0->1, overrun stays 0.
- Async rst_n low mid-SEND -> out_valid=0, ack=0 immediately; after release first grant is channel 0; enable=0 -> tick never asserts.
